// File: rtl/ysyx_22050710_sram_arbiter.sv
// ysyx_22050710_sram_arbiter
// Shares one single-port synchronous SRAM between the instruction fetch
// requester (read-only) and the load/store requester (read/write).
// At most one access is granted per cycle, with round-robin priority on
// contention. Read data returns one cycle after the grant and is routed to
// the requester that issued the access. Each requester's last read data is
// held between responses. A front-end redirect kills the pending fetch
// response.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_if_*                fetch request (req, addr, flush)
//   o_if_*                fetch grant, response valid, read data
//   i_ls_*                data request (req, wen, addr, wdata, wstrb)
//   o_ls_*                data grant, completion valid, read data
//   o_sram_*              SRAM command (en, byte wen, addr, wdata)
//   i_sram_rdata          SRAM read data, one cycle after an enabled read
module ysyx_22050710_sram_arbiter #(
  parameter int SRAM_ADDR_WD = 32,
  parameter int SRAM_DATA_WD = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_if_req,
  input  logic [SRAM_ADDR_WD-1:0]   i_if_addr,
  input  logic                      i_if_flush,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic [SRAM_DATA_WD-1:0]   o_if_rdata,
  input  logic                      i_ls_req,
  input  logic                      i_ls_wen,
  input  logic [SRAM_ADDR_WD-1:0]   i_ls_addr,
  input  logic [SRAM_DATA_WD-1:0]   i_ls_wdata,
  input  logic [SRAM_DATA_WD/8-1:0] i_ls_wstrb,
  output logic                      o_ls_gnt,
  output logic                      o_ls_rvalid,
  output logic [SRAM_DATA_WD-1:0]   o_ls_rdata,
  output logic                      o_sram_en,
  output logic [SRAM_DATA_WD/8-1:0] o_sram_wen,
  output logic [SRAM_ADDR_WD-1:0]   o_sram_addr,
  output logic [SRAM_DATA_WD-1:0]   o_sram_wdata,
  input  logic [SRAM_DATA_WD-1:0]   i_sram_rdata
);

  // last_gnt: 0 = fetch won last, 1 = data won last.
  logic                    last_gnt_q, last_gnt_d;
  logic                    rsp_vld_q,  rsp_vld_d;
  logic                    rsp_own_q,  rsp_own_d;
  logic                    rsp_kill_q, rsp_kill_d;
  logic                    rsp_wr_q,   rsp_wr_d;
  logic [SRAM_DATA_WD-1:0] if_hold_q,  if_hold_d;
  logic [SRAM_DATA_WD-1:0] ls_hold_q,  ls_hold_d;

  logic gnt_if;
  logic gnt_ls;
  logic if_rsp;
  logic ls_rsp;
  logic ls_rd_rsp;

  // Grants are gated by reset so every output reads 0 while reset is held,
  // even with requests asserted.
  always_comb begin
    gnt_if = i_rst & i_if_req & (~i_ls_req | last_gnt_q);
    gnt_ls = i_rst & i_ls_req & (~i_if_req | ~last_gnt_q);
  end

  // The flush input kills a response that lands in the same cycle as well as
  // the one issued this cycle (recorded in rsp_kill).
  always_comb begin
    if_rsp    = rsp_vld_q & ~rsp_own_q & ~rsp_kill_q & ~i_if_flush;
    ls_rsp    = rsp_vld_q & rsp_own_q;
    ls_rd_rsp = ls_rsp & ~rsp_wr_q;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_if | gnt_ls) begin
      last_gnt_d = gnt_ls;
    end
    rsp_vld_d  = gnt_if | gnt_ls;
    rsp_own_d  = gnt_ls;
    rsp_kill_d = gnt_if & i_if_flush;
    rsp_wr_d   = gnt_ls & i_ls_wen;
    if_hold_d  = if_rsp ? i_sram_rdata : if_hold_q;
    ls_hold_d  = ls_rd_rsp ? i_sram_rdata : ls_hold_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_gnt_q <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= 1'b0;
      rsp_kill_q <= 1'b0;
      rsp_wr_q   <= 1'b0;
      if_hold_q  <= '0;
      ls_hold_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_own_q  <= rsp_own_d;
      rsp_kill_q <= rsp_kill_d;
      rsp_wr_q   <= rsp_wr_d;
      if_hold_q  <= if_hold_d;
      ls_hold_q  <= ls_hold_d;
    end
  end

  always_comb begin
    o_if_gnt     = gnt_if;
    o_ls_gnt     = gnt_ls;
    o_sram_en    = gnt_if | gnt_ls;
    o_sram_wen   = (gnt_ls & i_ls_wen) ? i_ls_wstrb : '0;
    o_sram_addr  = gnt_if ? i_if_addr : (gnt_ls ? i_ls_addr : '0);
    o_sram_wdata = gnt_ls ? i_ls_wdata : '0;
    o_if_rvalid  = if_rsp;
    o_ls_rvalid  = ls_rsp;
    o_if_rdata   = if_rsp ? i_sram_rdata : if_hold_q;
    o_ls_rdata   = ls_rd_rsp ? i_sram_rdata : ls_hold_q;
  end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
module tb_ysyx_22050710_sram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_if_flush;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [63:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_wen;
  logic [31:0] i_ls_addr;
  logic [63:0] i_ls_wdata;
  logic [7:0]  i_ls_wstrb;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [63:0] o_ls_rdata;
  logic        o_sram_en;
  logic [7:0]  o_sram_wen;
  logic [31:0] o_sram_addr;
  logic [63:0] o_sram_wdata;
  logic [63:0] i_sram_rdata;

  ysyx_22050710_sram_arbiter #(.SRAM_ADDR_WD(32), .SRAM_DATA_WD(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_sram_en(o_sram_en), .o_sram_wen(o_sram_wen), .o_sram_addr(o_sram_addr),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who won the most recent contention-relevant grant,
  // the list of accesses awaiting their response, and each side's held data.
  typedef struct packed {
    bit is_ls;
    bit is_wr;
    bit killed;
  } acc_t;
  acc_t        pend[$];
  bit          m_ls_won_last;
  logic [63:0] m_if_hold;
  logic [63:0] m_ls_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_ls_won_last = 1'b0;
    m_if_hold = '0;
    m_ls_hold = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"}, {63'd0, o_if_gnt}, 64'd0);
    chk({tag, ".ls_gnt"}, {63'd0, o_ls_gnt}, 64'd0);
    chk({tag, ".if_rvalid"}, {63'd0, o_if_rvalid}, 64'd0);
    chk({tag, ".ls_rvalid"}, {63'd0, o_ls_rvalid}, 64'd0);
    chk({tag, ".sram_en"}, {63'd0, o_sram_en}, 64'd0);
    chk({tag, ".sram_wen"}, {56'd0, o_sram_wen}, 64'd0);
    chk({tag, ".sram_addr"}, {32'd0, o_sram_addr}, 64'd0);
    chk({tag, ".sram_wdata"}, o_sram_wdata, 64'd0);
    chk({tag, ".if_rdata"}, o_if_rdata, 64'd0);
    chk({tag, ".ls_rdata"}, o_ls_rdata, 64'd0);
  endtask

  // One clock cycle. Entered 1 time unit after a rising edge; drives inputs,
  // checks every output against the model mid-cycle, then advances the model.
  // rd is what the SRAM presents this cycle (the answer to last cycle's read).
  task automatic step(input bit ifr, input logic [31:0] ifa, input bit fl,
                      input bit lsr, input bit wen, input logic [31:0] lsa,
                      input logic [63:0] wd, input logic [7:0] ws,
                      input logic [63:0] rd);
    bit          want_ls, win_if, win_ls, has_rsp, exp_if_rv, exp_ls_rv, ls_read;
    acc_t        cur;
    logic [63:0] exp_if_rd, exp_ls_rd;
    i_if_req = ifr; i_if_addr = ifa; i_if_flush = fl;
    i_ls_req = lsr; i_ls_wen = wen; i_ls_addr = lsa;
    i_ls_wdata = wd; i_ls_wstrb = ws; i_sram_rdata = rd;
    #3;
    // Round robin: on contention the side that did not win last time wins.
    want_ls = lsr && (!ifr || !m_ls_won_last);
    win_ls  = want_ls;
    win_if  = ifr && !want_ls;
    has_rsp = (pend.size() > 0);
    cur     = has_rsp ? pend[0] : '0;
    exp_if_rv = has_rsp && !cur.is_ls && !cur.killed && !fl;
    exp_ls_rv = has_rsp && cur.is_ls;
    ls_read   = exp_ls_rv && !cur.is_wr;
    exp_if_rd = exp_if_rv ? rd : m_if_hold;
    exp_ls_rd = ls_read ? rd : m_ls_hold;
    chk("if_gnt", {63'd0, o_if_gnt}, {63'd0, win_if});
    chk("ls_gnt", {63'd0, o_ls_gnt}, {63'd0, win_ls});
    chk("sram_en", {63'd0, o_sram_en}, {63'd0, win_if | win_ls});
    chk("sram_wen", {56'd0, o_sram_wen}, (win_ls && wen) ? {56'd0, ws} : 64'd0);
    chk("sram_addr", {32'd0, o_sram_addr}, win_if ? {32'd0, ifa} : (win_ls ? {32'd0, lsa} : 64'd0));
    chk("sram_wdata", o_sram_wdata, win_ls ? wd : 64'd0);
    chk("if_rvalid", {63'd0, o_if_rvalid}, {63'd0, exp_if_rv});
    chk("ls_rvalid", {63'd0, o_ls_rvalid}, {63'd0, exp_ls_rv});
    chk("if_rdata", o_if_rdata, exp_if_rd);
    chk("ls_rdata", o_ls_rdata, exp_ls_rd);
    m_if_hold = exp_if_rd;
    m_ls_hold = exp_ls_rd;
    if (has_rsp) void'(pend.pop_front());
    if (win_if || win_ls) begin
      pend.push_back('{is_ls: win_ls, is_wr: win_ls && wen, killed: win_if && fl});
      m_ls_won_last = win_ls;
    end
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    i_rst = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0; i_if_flush = 1'b0;
    i_ls_req = 1'b0; i_ls_wen = 1'b0; i_ls_addr = '0;
    i_ls_wdata = '0; i_ls_wstrb = '0; i_sram_rdata = '0;
    model_reset();
    #1;
    chk_all_zero("reset");
    // Requests during reset must not be granted.
    i_if_req = 1'b1; i_ls_req = 1'b1; i_if_addr = 32'h1234; i_ls_addr = 32'h5678;
    #1;
    chk_all_zero("reset_req");
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b1;

    // Fetch only, three back-to-back accesses.
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h0);
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h13);
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h93);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h113);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'hAAAA);
    chk("if_hold_0x113", o_if_rdata, 64'h113);

    // Data read to load ls_hold, then a write which must not disturb it.
    step(0, 0, 0, 1, 0, 32'h100, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444);
    step(0, 0, 0, 1, 1, 32'h108, 64'hDEAD_BEEF, 8'h0F, 64'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h5555_6666);
    chk("ls_hold_after_wr", o_ls_rdata, 64'h1111_2222_3333_4444);

    // Flush in the grant cycle, then flush only in the response cycle
    // (which also kills a fetch granted in that cycle).
    step(1, 32'h200, 1, 0, 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h77);
    step(1, 32'h204, 0, 0, 0, 0, 0, 0, 64'h0);
    step(1, 32'h208, 1, 0, 0, 0, 0, 0, 64'h88);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h99);
    chk("if_hold_after_flush", o_if_rdata, 64'h113);

    // Asynchronous reset between a grant and its response.
    step(1, 32'h300, 0, 1, 0, 32'h400, 0, 0, 64'h0);
    i_if_req = 1'b1; i_ls_req = 1'b1; i_sram_rdata = 64'hCAFE;
    #2;
    i_rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge i_clk); #1;
    chk_all_zero("async_reset_hold");
    i_rst = 1'b1;

    // Contention straight after reset: data, fetch, data, fetch.
    step(1, 32'h500, 0, 1, 0, 32'h600, 0, 0, 64'hBEEF);
    step(1, 32'h504, 0, 1, 0, 32'h604, 0, 0, 64'h10);
    step(1, 32'h508, 0, 1, 1, 32'h608, 64'h42, 8'hF0, 64'h20);
    step(1, 32'h50C, 0, 1, 0, 32'h60C, 0, 0, 64'h30);
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'h40);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1), $urandom, ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
           rnd64(), 8'($urandom), rnd64());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
# ysyx_22050710_sram_arbiter

Shares one single-port synchronous SRAM between the fetch stage (read-only instruction requester) and the load/store path (read/write data requester). It grants at most one access per cycle with round-robin priority, routes the one-cycle-latency read data back to the requester that issued the access, and holds each requester's last read data stable between accesses. It also discards an in-flight fetch response when the front end redirects.

## Interface
- SRAM_ADDR_WD, 32: SRAM and requester address width
- SRAM_DATA_WD, 64: SRAM data width, a multiple of 8
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_if_req  in  1  fetch access request
- i_if_addr  in  SRAM_ADDR_WD  fetch address
- i_if_flush  in  1  front-end redirect; kills the pending fetch response
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  SRAM_DATA_WD  fetch read data, held until next fetch response
- i_ls_req  in  1  data access request
- i_ls_wen  in  1  1 = write, 0 = read
- i_ls_addr  in  SRAM_ADDR_WD  data address
- i_ls_wdata  in  SRAM_DATA_WD  write data
- i_ls_wstrb  in  SRAM_DATA_WD/8  byte write strobes
- o_ls_gnt  out  1  data request accepted this cycle
- o_ls_rvalid  out  1  data access complete: read data valid, or write acknowledged
- o_ls_rdata  out  SRAM_DATA_WD  data read data, held until next data read response
- o_sram_en  out  1  SRAM access enable
- o_sram_wen  out  SRAM_DATA_WD/8  SRAM byte write enables; 0 = read
- o_sram_addr  out  SRAM_ADDR_WD  SRAM address
- o_sram_wdata  out  SRAM_DATA_WD  SRAM write data
- i_sram_rdata  in  SRAM_DATA_WD  SRAM read data, valid one cycle after an enabled read

## Operation
- Arbitration is combinational on the current requests and the registered `last_gnt` bit (0 = fetch, 1 = data).
- Only one request high: grant it.
- Both requests high: grant the requester not named by `last_gnt`.
- Neither request high: no grant, o_sram_en = 0, all other SRAM outputs = 0.
- `last_gnt` updates to the granted requester on every grant. Its reset value is 0, so data wins the first contention.
- SRAM command during a fetch grant: en = 1, wen = 0, addr = i_if_addr, wdata = 0.
- SRAM command during a data grant: en = 1, addr = i_ls_addr, wdata = i_ls_wdata, wen = i_ls_wen ? i_ls_wstrb : 0.
- Response tracking uses registers `rsp_vld`, `rsp_own`, `rsp_kill`, loaded every cycle:
  - rsp_vld = any grant.
  - rsp_own = granted requester.
  - rsp_kill = fetch granted and i_if_flush high.
- Fetch response: o_if_rvalid = rsp_vld & (rsp_own == 0) & ~rsp_kill & ~i_if_flush.
- Data response: o_ls_rvalid = rsp_vld & (rsp_own == 1). Data responses are never killed.
- Read-data hold registers `if_hold` and `ls_hold`:
  - if_hold captures i_sram_rdata whenever o_if_rvalid = 1.
  - ls_hold captures i_sram_rdata on a data read response only; write acks leave it unchanged.
  - o_if_rdata = o_if_rvalid ? i_sram_rdata : if_hold.
  - o_ls_rdata = (data read response) ? i_sram_rdata : ls_hold. The registered write flag is part of the response state.
- Requesters always accept responses; there is no response backpressure.
- A requester may hold req high across cycles. Each granted cycle is a separate access.

## Timing
- Grant: same cycle as the request, zero latency.
- SRAM command: issued in the grant cycle N. Response (rvalid and data) in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating requesters are legal. Responses are pipelined with one outstanding access per cycle.
- Contention with both requesting every cycle: grants alternate data, fetch, data, fetch, ... starting with data after reset.
- Flush in the grant cycle N: the access still reaches the SRAM; no fetch rvalid in N+1.
- Flush in N+1: rvalid is suppressed in N+1; a new fetch granted in N+1 is also killed.
- Reset asserted (i_rst = 0), at any time including mid-access:
  - All outputs read 0; SRAM disabled; gnt = 0, rvalid = 0.
  - rsp_vld = 0, last_gnt = 0, if_hold = ls_hold = 0.
  - Any in-flight response is dropped.
- Reset release: arbitration resumes on the first rising edge after release.

## Test plan
- Fetch only: if_req with addr 0x80000000 for 3 cycles; SRAM returns 0x13, 0x93, 0x113 -> if_gnt in each cycle; if_rvalid in cycles 2–4 with data in order; o_if_rdata holds 0x113 afterwards.
- Contention: both requests high for 4 cycles after reset -> grant order data, fetch, data, fetch; each rvalid lands on the owner one cycle after its grant.
- Data write: ls_req, wen = 1, wstrb = 0x0F, wdata = 0xDEADBEEF -> o_sram_wen = 0x0F in the grant cycle; ls_rvalid next cycle; ls_rdata keeps the prior read value.
- Flush: fetch granted in cycle N with i_if_flush high in N -> no if_rvalid in N+1; if_rdata unchanged. Repeat with flush only in N+1 -> same result.
- Async reset: assert i_rst = 0 mid-cycle between a grant and its response -> outputs go to 0 immediately; no rvalid after release; next contention grants data first.
